// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_write_arbiter
//  Purpose  : Round-robin, burst-holding arbiter that shares the single
//             framebuffer write port among NUM_REQ pixel producers and
//             registers every accepted beat before it reaches block RAM.
//  Options  : FB_ARB_BOUND_CHECK_EN - suppress writes to addr >= FB_PIXELS
//             and count them in drop_count_o.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module fb_write_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int ADDR_WIDTH  = `DISP_ADDR_WIDTH,
   parameter int FB_PIXELS   = 76800,
   parameter int MAX_BURST   = 64,
   parameter int STALL_LIMIT = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ-1:0]            req_last_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*32-1:0]         req_data_i,
   output logic                          fb_we_o,
   output logic [ADDR_WIDTH-1:0]         fb_addr_o,
   output logic [31:0]                   fb_wdata_o,
   output logic [1:0]                    grant_id_o,
   output logic                          busy_o,
   output logic [15:0]                   drop_count_o
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam int         STALL_W        = $clog2(STALL_LIMIT + 1);
   localparam logic [6:0] BEAT_LAST      = 7'(MAX_BURST - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
   // last_owner starts at the top index so requester 0 is searched first
   localparam logic [1:0] LAST_OWNER_RST = 2'(NUM_REQ - 1);

   logic [0:0]         state_q, state_d;
   logic [1:0]         owner_q;
   logic [1:0]         last_owner_q;
   logic [6:0]         beat_cnt_q;
   logic [STALL_W-1:0] stall_cnt_q;
   logic               fb_we_q;
   logic [ADDR_WIDTH-1:0] fb_addr_q;
   logic [31:0]        fb_wdata_q;

   logic                  w_any_valid;
   logic [1:0]            w_winner;
   logic                  w_own_valid;
   logic                  w_own_last;
   logic [ADDR_WIDTH-1:0] w_own_addr;
   logic [31:0]           w_own_data;
   logic                  w_accept;
   logic                  w_release;
   logic                  w_in_range;

   // Owner-side view of the handshake; non-owners are never looked at here
   assign w_any_valid = |req_valid_i;
   assign w_own_valid = req_valid_i[owner_q];
   assign w_own_last  = req_last_i[owner_q];
   assign w_own_addr  = req_addr_i[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_own_data  = req_data_i[int'(owner_q)*32 +: 32];
   assign w_accept    = (state_q == ST_GRANT) && w_own_valid;

   // Burst ends on last, on the MAX_BURST-th beat, or when the owner goes quiet too long
   assign w_release = (w_accept && (w_own_last || (beat_cnt_q == BEAT_LAST)))
                   || ((state_q == ST_GRANT) && !w_own_valid && (stall_cnt_q == STALL_LAST));

   // Round-robin search starting just above the previous owner; the lowest offset wins
   always_comb begin
      w_winner = last_owner_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req_valid_i[(int'(last_owner_q) + k) % NUM_REQ]) begin
            w_winner = 2'((int'(last_owner_q) + k) % NUM_REQ);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (w_any_valid) state_d = ST_GRANT;
         ST_GRANT: if (w_release)   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: ready depends only on state and owner, never on valid
   always_comb begin
      req_ready_o = '0;
      if (state_q == ST_GRANT) begin
         req_ready_o[owner_q] = 1'b1;
      end
   end

   // Grant bookkeeping: owner capture, burst length and stall counters
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         owner_q      <= 2'd0;
         last_owner_q <= LAST_OWNER_RST;
         beat_cnt_q   <= 7'd0;
         stall_cnt_q  <= '0;
      end else if (state_q == ST_IDLE) begin
         if (w_any_valid) begin
            owner_q      <= w_winner;
            last_owner_q <= w_winner;
            beat_cnt_q   <= 7'd0;
            stall_cnt_q  <= '0;
         end
      end else if (w_accept) begin
         beat_cnt_q  <= beat_cnt_q + 7'd1;
         stall_cnt_q <= '0;
      end else if (stall_cnt_q != STALL_LAST) begin
         stall_cnt_q <= stall_cnt_q + STALL_W'(1);
      end
   end

`ifdef FB_ARB_BOUND_CHECK_EN
   logic [15:0] drop_count_q;

   assign w_in_range = (32'(w_own_addr) < 32'(FB_PIXELS));

   // Saturating tally of handshaken beats whose write was suppressed
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         drop_count_q <= 16'd0;
      end else if (w_accept && !w_in_range && (drop_count_q != 16'hFFFF)) begin
         drop_count_q <= drop_count_q + 16'd1;
      end
   end

   assign drop_count_o = drop_count_q;
`else
   assign w_in_range   = 1'b1;
   assign drop_count_o = 16'd0;
`endif

   // Write register stage: one fb_we pulse per accepted, in-range beat
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_wdata_q <= 32'd0;
      end else begin
         fb_we_q <= w_accept && w_in_range;
         if (w_accept) begin
            fb_addr_q  <= w_own_addr;
            fb_wdata_q <= w_own_data;
         end
      end
   end

   assign fb_we_o    = fb_we_q;
   assign fb_addr_o  = fb_addr_q;
   assign fb_wdata_o = fb_wdata_q;
   assign busy_o     = (state_q == ST_GRANT);
   assign grant_id_o = owner_q;

endmodule

`default_nettype wire

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single framebuffer write port (display port A) among up to NUM_REQ pixel producers (game renderer, text/score overlay, test-pattern source). Requesters present address/data beats over a valid/ready handshake and are granted in round-robin order. A grant is held for a whole burst, so one producer's raster run is not interleaved with another's. The block sits between the producers and the display module and registers every write before it reaches block RAM.

## Interface
- NUM_REQ, 3: number of requesters (2..4).
- ADDR_WIDTH, `DISP_ADDR_WIDTH: framebuffer address width.
- FB_PIXELS, 76800: number of valid framebuffer addresses (320×240).
- MAX_BURST, 64: maximum beats per grant before forced release.
- STALL_LIMIT, 16: consecutive owner-idle cycles before forced release.

- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  beat valid, one bit per requester
- req_ready  out  NUM_REQ  beat accepted this cycle when valid&ready
- req_last  in  NUM_REQ  marks final beat of a burst
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*32  packed write data, colour in [31:20]
- fb_we  out  1  framebuffer write enable
- fb_addr  out  ADDR_WIDTH  framebuffer write address
- fb_wdata  out  32  framebuffer write data
- grant_id  out  2  current owner index; valid while busy=1
- busy  out  1  a grant is active
- drop_count  out  16  saturating count of suppressed out-of-range beats

## Operation
- FSM has two states, IDLE and GRANT.
- IDLE: if any req_valid is set, select the first requester with valid set, searching from (last_owner+1) mod NUM_REQ upward with wrap. Register owner=winner and last_owner=winner, clear beat_cnt and stall_cnt, and go to GRANT. Otherwise stay in IDLE.
- GRANT: req_ready[owner] = 1; all other ready bits are 0. req_ready is combinational from state and owner only, never from req_valid.
- An accepted beat is req_valid[owner] & req_ready[owner]. The block registers fb_addr/fb_wdata from that requester's slice and sets fb_we=1 on the next edge.
- Each accepted beat increments beat_cnt, which is 7 bits wide and compared against MAX_BURST-1.
- A cycle in GRANT with req_valid[owner]=0 increments stall_cnt. Any accepted beat clears stall_cnt.
- Release goes to IDLE on any of these:
  - accepted beat with req_last=1;
  - accepted beat with beat_cnt==MAX_BURST-1;
  - stall_cnt reaching STALL_LIMIT-1 while still idle.
- A released requester that is still valid is re-arbitrated normally. It wins again only if no other requester is valid.
- Data and valid on non-granted requesters are ignored. They must hold until ready, per normal handshake rules.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_wdata=0, req_ready=0, busy=0, grant_id=0, drop_count=0, state=IDLE, last_owner=NUM_REQ-1 so requester 0 wins first.
- Reset asserted mid-burst aborts immediately. The pending registered beat is lost and fb_we falls with reset.
- Arbitration latency: valid seen in IDLE at cycle N gives ready high at cycle N+1.
- Write latency: beat accepted at edge N gives fb_we/fb_addr/fb_wdata valid for cycle N+1 to N+2, for exactly one cycle per beat.
- Throughput is one beat per cycle within a burst. Each handover costs exactly one IDLE cycle.
- Release is taken on the accepting edge, so req_ready is 0 in the cycle after a last beat.
- busy and grant_id are registered and equal (state==GRANT) and owner.
- fb_we=0 in every cycle without a beat accepted on the previous edge.

## Configuration
- FB_ARB_BOUND_CHECK_EN defined:
  - accepted beats with addr ≥ FB_PIXELS are still handshaken, but fb_we stays 0 for them;
  - drop_count increments, saturating at 16'hFFFF;
  - they count toward beat_cnt and release normally.
- Not defined: every accepted beat is written unchanged, drop_count is tied to 0, and no comparator is built.

## Test plan
- Reset, then requester 0 sends a 4-beat burst at addr 100..103 with last on beat 4. Expect ready high 1 cycle after valid, fb_we high for 4 consecutive cycles with addr 100..103, then busy=0.
- Requesters 0, 1 and 2 all hold valid with 2-beat bursts. Expect grant order 0,1,2,0, one IDLE cycle between bursts, and no beat interleaving.
- Requester 1 streams 70 beats with no last. Expect forced release after 64 accepted beats. Requester 2 (valid) is granted next, then requester 1 resumes.
- Owner drops valid after 2 beats. Expect release after 16 idle cycles and busy=0. A waiting requester is granted on the following cycle.
- With FB_ARB_BOUND_CHECK_EN, write to addr 76800 then 76799. Expect the first beat is accepted with fb_we=0 and drop_count=1, and the second is written.
- Assert reset mid-burst on beat 3 of 8. Expect fb_we=0, req_ready=0 and busy=0 immediately. After reset, requester 0 wins first.
